// File: rtl/sc_reg_lane_shifter.sv
// Multi-lane rotating pattern register with per-lane period counters and an optional collision probe.
// Optional feature: define LANE_SHIFTER_HIT_EN to build the player/lane collision comparator.

module sc_reg_lane_shifter_lane #(
    parameter int                   DATAWIDTH    = 8,
    parameter int                   PERIODWIDTH  = 8,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN = '0
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   clrN,
    input  logic                   ld,
    input  logic [DATAWIDTH-1:0]   ldData,
    input  logic [PERIODWIDTH-1:0] ldPeriod,
    input  logic                   ldDir,
    input  logic                   en,
    output logic [DATAWIDTH-1:0]   pattern,
    output logic                   tick
);

    logic [PERIODWIDTH-1:0] period;
    logic [PERIODWIDTH-1:0] counter;
    logic                   dir;

    always_ff @(posedge clk) begin
        tick <= 1'b0;
        if (!rstN) begin
            pattern <= '0;
            period  <= '0;
            dir     <= 1'b0;
            counter <= '0;
        end else if (!clrN) begin
            pattern <= INIT_PATTERN;
            counter <= '0;
        end else if (ld) begin
            pattern <= ldData;
            period  <= ldPeriod;
            dir     <= ldDir;
            counter <= '0;
        end else if (en && (period != '0)) begin
            // Counter runs 0..period, so a rotation lands every period+1 cycles.
            if (counter == period) begin
                counter <= '0;
                pattern <= dir ? {pattern[0], pattern[DATAWIDTH-1:1]}
                               : {pattern[DATAWIDTH-2:0], pattern[DATAWIDTH-1]};
                tick    <= 1'b1;
            end else begin
                counter <= counter + 1'b1;
            end
        end
    end

endmodule

module sc_reg_lane_shifter #(
    parameter int                   DATAWIDTH    = 8,
    parameter int                   LANES        = 4,
    parameter int                   PERIODWIDTH  = 8,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN = '0
) (
    input  logic                         SC_RegLANESHIFTER_CLOCK_50,
    input  logic                         SC_RegLANESHIFTER_RESET_InLow,
    input  logic                         SC_RegLANESHIFTER_clear_InLow,
    input  logic                         SC_RegLANESHIFTER_load_InLow,
    input  logic [$clog2(LANES)-1:0]     SC_RegLANESHIFTER_laneSel_InBUS,
    input  logic [DATAWIDTH-1:0]         SC_RegLANESHIFTER_data_InBUS,
    input  logic [PERIODWIDTH-1:0]       SC_RegLANESHIFTER_period_InBUS,
    input  logic                         SC_RegLANESHIFTER_dir_In,
    input  logic                         SC_RegLANESHIFTER_enable_In,
    input  logic [$clog2(LANES):0]       SC_RegLANESHIFTER_playerLane_InBUS,
    input  logic [DATAWIDTH-1:0]         SC_RegLANESHIFTER_playerMask_InBUS,
    output logic [LANES*DATAWIDTH-1:0]   SC_RegLANESHIFTER_data_OutBUS,
    output logic [LANES-1:0]             SC_RegLANESHIFTER_tick_OutBUS,
    output logic                         SC_RegLANESHIFTER_hit_Out
);

    localparam int SELW = $clog2(LANES);
    localparam int PLW  = $clog2(LANES) + 1;

    logic [LANES-1:0][DATAWIDTH-1:0] lanePattern;

    // An out-of-range laneSel matches no instance, so such a load touches nothing.
    for (genvar i = 0; i < LANES; i++) begin : gLane
        sc_reg_lane_shifter_lane #(
            .DATAWIDTH   (DATAWIDTH),
            .PERIODWIDTH (PERIODWIDTH),
            .INIT_PATTERN(INIT_PATTERN)
        ) uLane (
            .clk     (SC_RegLANESHIFTER_CLOCK_50),
            .rstN    (SC_RegLANESHIFTER_RESET_InLow),
            .clrN    (SC_RegLANESHIFTER_clear_InLow),
            .ld      (!SC_RegLANESHIFTER_load_InLow &&
                      (SC_RegLANESHIFTER_laneSel_InBUS == SELW'(i))),
            .ldData  (SC_RegLANESHIFTER_data_InBUS),
            .ldPeriod(SC_RegLANESHIFTER_period_InBUS),
            .ldDir   (SC_RegLANESHIFTER_dir_In),
            .en      (SC_RegLANESHIFTER_enable_In),
            .pattern (lanePattern[i]),
            .tick    (SC_RegLANESHIFTER_tick_OutBUS[i])
        );
    end

    assign SC_RegLANESHIFTER_data_OutBUS = lanePattern;

`ifdef LANE_SHIFTER_HIT_EN
    logic hitNext;

    always_comb begin
        hitNext = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (SC_RegLANESHIFTER_playerLane_InBUS == PLW'(i))
                hitNext = |(lanePattern[i] & SC_RegLANESHIFTER_playerMask_InBUS);
        end
    end

    always_ff @(posedge SC_RegLANESHIFTER_CLOCK_50) begin
        if (!SC_RegLANESHIFTER_RESET_InLow) SC_RegLANESHIFTER_hit_Out <= 1'b0;
        else                                SC_RegLANESHIFTER_hit_Out <= hitNext;
    end
`else
    logic unusedPlayer;
    assign unusedPlayer = ^{SC_RegLANESHIFTER_playerLane_InBUS, SC_RegLANESHIFTER_playerMask_InBUS};
    assign SC_RegLANESHIFTER_hit_Out = 1'b0;
`endif

endmodule

// File: doc/sc_reg_lane_shifter.md
SC_REG_LANE_SHIFTER -- requirements
Module: sc_reg_lane_shifter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, bits per lane.
REQ-002 SHALL have parameter LANES, default 4, number of independent lanes (2..16).
REQ-003 SHALL have parameter PERIODWIDTH, default 8, width of per-lane shift-period counter.
REQ-004 SHALL have parameter INIT_PATTERN, default 8'b00000000 replicated per lane, DATAWIDTH-bit value loaded by clear.
REQ-005 SHALL have ports: SC_RegLANESHIFTER_CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have: SC_RegLANESHIFTER_RESET_InLow  in  1  reset, synchronous, active-low.
REQ-007 SHALL have: SC_RegLANESHIFTER_clear_InLow  in  1  active-low clear of all lanes.
REQ-008 SHALL have: SC_RegLANESHIFTER_load_InLow  in  1  active-low load of selected lane.
REQ-009 SHALL have: SC_RegLANESHIFTER_laneSel_InBUS  in  clog2(LANES)  lane index for load.
REQ-010 SHALL have: SC_RegLANESHIFTER_data_InBUS  in  DATAWIDTH  lane pattern for load.
REQ-011 SHALL have: SC_RegLANESHIFTER_period_InBUS  in  PERIODWIDTH  shift period for load.
REQ-012 SHALL have: SC_RegLANESHIFTER_dir_In  in  1  direction for load; 0 rotate-left, 1 rotate-right.
REQ-013 SHALL have: SC_RegLANESHIFTER_enable_In  in  1  high = lanes run, low = all counters/lanes hold.
REQ-014 SHALL have: SC_RegLANESHIFTER_playerLane_InBUS  in  clog2(LANES)+1  lane probed for collision.
REQ-015 SHALL have: SC_RegLANESHIFTER_playerMask_InBUS  in  DATAWIDTH  player position one-hot/mask.
REQ-016 SHALL have: SC_RegLANESHIFTER_data_OutBUS  out  LANES*DATAWIDTH  lane i at bits [i*DATAWIDTH +: DATAWIDTH], registered.
REQ-017 SHALL have: SC_RegLANESHIFTER_tick_OutBUS  out  LANES  bit i = 1-cycle pulse in cycle after lane i rotated.
REQ-018 SHALL have: SC_RegLANESHIFTER_hit_Out  out  1  registered collision flag.

Function
REQ-019 Per lane state SHALL be: pattern (DATAWIDTH), period (PERIODWIDTH), dir (1), counter (PERIODWIDTH).
REQ-020 Priority per edge SHALL be: reset > clear > load > rotate > hold.
REQ-021 Clear SHALL set every pattern to INIT_PATTERN and every counter to 0; periods and dirs retained; no tick.
REQ-022 Load SHALL write data/period/dir into lane laneSel, zero its counter, no tick for that lane; other lanes continue normally same cycle.
REQ-023 laneSel >= LANES with load active SHALL be ignored (no lane modified).
REQ-024 With enable high and period != 0: counter==period -> counter<=0, pattern rotates one bit per dir, tick bit set next cycle; else counter<=counter+1.
REQ-025 Rotation interval SHALL be exactly period+1 cycles; period=0 SHALL freeze lane (counter held 0, no rotate, no tick).
REQ-026 Rotate-left SHALL be {p[DATAWIDTH-2:0],p[DATAWIDTH-1]}; rotate-right {p[0],p[DATAWIDTH-1:1]}; wrap-around lossless.
REQ-027 enable low SHALL hold all counters and patterns; tick outputs 0; resumption continues from held counter.
REQ-028 hit_Out SHALL be registered |(pattern[playerLane] & playerMask) using pre-edge register contents (1-cycle latency).
REQ-029 playerLane >= LANES SHALL give hit_Out=0 next cycle.

Reset
REQ-030 On RESET_InLow=0 at an edge: all patterns, periods, dirs, counters = 0; data_OutBUS=0, tick_OutBUS=0, hit_Out=0.
REQ-031 Reset mid-rotation SHALL abort it; no tick after reset; reset SHALL NOT be asynchronous (no effect between edges).

Configuration
REQ-032 Macro LANE_SHIFTER_HIT_EN defined: collision logic per REQ-028/029 present.
REQ-033 Macro undefined: comparator omitted, hit_Out tied 0, playerLane/playerMask ports present but unused.

Verification
REQ-034 Reset, load lane0 data=8'b00000001 period=2 dir=0, enable=1 -> lane0 = 00000010 after 3 cycles, 00000100 after 6; tick_OutBUS[0] pulses every 3 cycles.
REQ-035 Load lane1 data=8'b00000001 period=0 dir=1, run 50 cycles -> lane1 stays 00000001, tick_OutBUS[1] never 1; then period=1 reload -> 10000000 after 2 cycles (right wrap).
REQ-036 Lanes running, clear_InLow=0 with load_InLow=0 same cycle, INIT_PATTERN=8'hF0 -> all lanes 8'hF0, counters 0, load ignored, periods unchanged.
REQ-037 Lane2=8'b00011000, playerLane=2, mask=8'b00001000 -> hit_Out=1 next cycle; playerLane=7 (LANES=4) -> hit_Out=0; macro undefined -> hit_Out always 0.
REQ-038 enable=0 for 10 cycles mid-count (counter=1, period=3) -> no change; re-enable -> rotation after exactly 3 more cycles.
REQ-039 Assert RESET_InLow=0 for one edge while lane0 counter==period -> outputs all 0 next cycle, no tick, no rotation.
